// File: rtl/mlp_pkg.sv
// Shared types and helpers for the MLP neuron datapath.
package mlp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_e;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int PRODUCT_WIDTH  = 2 * DATA_WIDTH_DEF;
    localparam int SAT_W          = 64;

    typedef struct packed {
        logic signed [SAT_W-1:0] sum;
        logic                    ovf;
    } sat_res_t;

    // Operands arrive sign-extended from a width-bit range, so the wide add never wraps.
    function automatic sat_res_t sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int                      width
    );
        logic signed [SAT_W-1:0] s;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_res_t r;
        s  = a + b;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        r.ovf = (s > hi) || (s < lo);
        r.sum = (s > hi) ? hi : ((s < lo) ? lo : s);
        return r;
    endfunction

endpackage

// File: rtl/mac_accumulator_mult.sv
// Combinational signed multiplier; isolated so it can be retimed later.
module signed_multiplier
    import mlp_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic signed [DATA_WIDTH-1:0]   a,
    input  logic signed [DATA_WIDTH-1:0]   b,
    output logic signed [2*DATA_WIDTH-1:0] p
);

    assign p = a * b;

endmodule

// File: rtl/mac_accumulator.sv
// Sequential MAC stage of one MLP neuron.
// Define MAC_SATURATE_EN for saturating adds and the sat_flag output.
module mac_accumulator
    import mlp_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int FRACTION_BIT = 4,
    parameter int ACC_WIDTH    = 24,
    parameter int NUM_INPUTS   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] x_in,
    input  logic signed [DATA_WIDTH-1:0] w_in,
    input  logic signed [DATA_WIDTH-1:0] bias_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [ACC_WIDTH-1:0]  acc_out
`ifdef MAC_SATURATE_EN
    ,
    output logic                         sat_flag
`endif
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(NUM_INPUTS + 1);
    localparam logic [CW-1:0] LAST = CW'(NUM_INPUTS);

    state_e                      state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        in_ready_q, in_ready_d;
    logic                        out_valid_q, out_valid_d;

    logic signed [PW-1:0]        product;
    logic signed [ACC_WIDTH-1:0] product_ext;
    logic signed [ACC_WIDTH-1:0] bias_ext;
    logic signed [ACC_WIDTH-1:0] add_a;
    logic signed [ACC_WIDTH-1:0] sum;
    logic                        accept;
    logic                        transfer;

    signed_multiplier #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mul (
        .a(x_in),
        .b(w_in),
        .p(product)
    );

    assign accept      = in_valid && in_ready_q;
    assign transfer    = out_valid_q && out_ready;
    assign product_ext = ACC_WIDTH'(product);
    assign bias_ext    = ACC_WIDTH'(bias_in) <<< FRACTION_BIT;
    // The first beat of an evaluation starts from the aligned bias.
    assign add_a       = (state_q == IDLE) ? bias_ext : acc_q;

`ifdef MAC_SATURATE_EN
    sat_res_t sat_r;
    logic     sat_q, sat_d;

    assign sat_r    = sat_add(SAT_W'(add_a), SAT_W'(product_ext), ACC_WIDTH);
    assign sum      = sat_r.sum[ACC_WIDTH-1:0];
    assign sat_flag = sat_q;

    always_comb begin
        sat_d = sat_q;
        if (accept) begin
            sat_d = (state_q == IDLE) ? sat_r.ovf : (sat_q | sat_r.ovf);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end
`else
    assign sum = add_a + product_ext;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = sum;
                    cnt_d   = CW'(1);
                    state_d = (LAST == CW'(1)) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = sum;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q + CW'(1) == LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (transfer) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d != DONE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign acc_out   = acc_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: default, 16-bit and single-input builds.
module tb_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  x = '0, w = '0, b = '0;
    logic        iv0 = 1'b0, iv1 = 1'b0, iv2 = 1'b0;
    logic        or0 = 1'b0, or1 = 1'b0, or2 = 1'b0;
    logic        rdy0, rdy1, rdy2;
    logic        ov0, ov1, ov2;
    logic [23:0] acc0;
    logic [15:0] acc1;
    logic [23:0] acc2;
`ifdef MAC_SATURATE_EN
    logic        sat0, sat1, sat2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_accumulator u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(rdy0),
        .x_in(x), .w_in(w), .bias_in(b), .out_valid(ov0),
        .out_ready(or0), .acc_out(acc0)
`ifdef MAC_SATURATE_EN
        , .sat_flag(sat0)
`endif
    );

    mac_accumulator #(.ACC_WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(rdy1),
        .x_in(x), .w_in(w), .bias_in(b), .out_valid(ov1),
        .out_ready(or1), .acc_out(acc1)
`ifdef MAC_SATURATE_EN
        , .sat_flag(sat1)
`endif
    );

    mac_accumulator #(.NUM_INPUTS(1)) u_n1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(rdy2),
        .x_in(x), .w_in(w), .bias_in(b), .out_valid(ov2),
        .out_ready(or2), .acc_out(acc2)
`ifdef MAC_SATURATE_EN
        , .sat_flag(sat2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int sel, input logic [7:0] xv, input logic [7:0] wv,
                        input logic [7:0] bv);
        int   t;
        logic r;
        t = 0;
        x = xv;
        w = wv;
        b = bv;
        case (sel)
            0: iv0 = 1'b1;
            1: iv1 = 1'b1;
            default: iv2 = 1'b1;
        endcase
        r = (sel == 0) ? rdy0 : ((sel == 1) ? rdy1 : rdy2);
        while (!r && t < 50) begin
            step();
            t++;
            r = (sel == 0) ? rdy0 : ((sel == 1) ? rdy1 : rdy2);
        end
        chk("beat_ready", 32'(r), 32'd1);
        step();
        iv0 = 1'b0;
        iv1 = 1'b0;
        iv2 = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_out_valid", 32'(ov0), 32'd0);
        chk("rst_acc_out", 32'(acc0), 32'd0);
        chk("rst_in_ready", 32'(rdy0), 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_in_ready", 32'(rdy0), 32'd1);

        // 16 x (1.0*1.0) + 0.5; bias on later beats must be ignored
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("t1_no_early_valid", 32'(ov0), 32'd0);
            beat(0, 8'h10, 8'h10, (i == 0) ? 8'h08 : 8'h7F);
        end
        chk("t1_valid", 32'(ov0), 32'd1);
        chk("t1_acc", 32'(acc0), 32'h001080);
        chk("t1_busy", 32'(rdy0), 32'd0);
        or0 = 1'b1;
        step();
        or0 = 1'b0;
        chk("t1_idle_valid", 32'(ov0), 32'd0);
        chk("t1_idle_ready", 32'(rdy0), 32'd1);
        chk("t1_acc_kept", 32'(acc0), 32'h001080);

        // Mixed signs: 16 x (-1.0*2.0)
        for (int i = 0; i < 16; i++) begin
            beat(0, 8'hF0, 8'h20, (i == 0) ? 8'h00 : 8'h55);
        end
        chk("t2_valid", 32'(ov0), 32'd1);
        chk("t2_acc", 32'(acc0), 32'hFFE000);
        or0 = 1'b1;
        step();
        or0 = 1'b0;

        // Gapped input, stalled output with in_valid pushing in DONE
        for (int i = 0; i < 16; i++) begin
            beat(0, 8'h10, 8'h10, (i == 0) ? 8'h08 : 8'h00);
            if (i < 15) step();
        end
        chk("t3_valid", 32'(ov0), 32'd1);
        chk("t3_acc", 32'(acc0), 32'h001080);
        iv0 = 1'b1;
        x = 8'h7F;
        w = 8'h7F;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t3_hold_valid", 32'(ov0), 32'd1);
            chk("t3_hold_acc", 32'(acc0), 32'h001080);
            chk("t3_hold_ready", 32'(rdy0), 32'd0);
        end
        or0 = 1'b1;
        step();
        iv0 = 1'b0;
        or0 = 1'b0;
        chk("t3_idle_valid", 32'(ov0), 32'd0);
        chk("t3_idle_ready", 32'(rdy0), 32'd1);
        chk("t3_acc_kept", 32'(acc0), 32'h001080);

        // Reset mid-evaluation discards the partial sum
        for (int i = 0; i < 7; i++) begin
            beat(0, 8'h10, 8'h10, 8'h08);
        end
        rst_n = 1'b0;
        #1;
        chk("t4_rst_acc", 32'(acc0), 32'd0);
        chk("t4_rst_valid", 32'(ov0), 32'd0);
        chk("t4_rst_ready", 32'(rdy0), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            beat(0, 8'h10, 8'h10, 8'h00);
        end
        chk("t4_valid", 32'(ov0), 32'd1);
        chk("t4_acc", 32'(acc0), 32'h001000);
        or0 = 1'b1;
        step();
        or0 = 1'b0;

        // 16-bit accumulator: 16 x (-8.0*-8.0)
        for (int i = 0; i < 16; i++) begin
            beat(1, 8'h80, 8'h80, 8'h00);
        end
        chk("t5_valid", 32'(ov1), 32'd1);
`ifdef MAC_SATURATE_EN
        chk("t5_acc_sat", 32'(acc1), 32'h7FFF);
        chk("t5_sat_flag", 32'(sat1), 32'd1);
`else
        chk("t5_acc_wrap", 32'(acc1), 32'h0000);
`endif
        or1 = 1'b1;
        step();
        or1 = 1'b0;

        // Single-input neuron
        chk("t6_idle_valid", 32'(ov2), 32'd0);
        beat(2, 8'h10, 8'h30, 8'h10);
        chk("t6_valid", 32'(ov2), 32'd1);
        chk("t6_acc", 32'(acc2), 32'h000400);
        or2 = 1'b1;
        step();
        or2 = 1'b0;
        chk("t6_after_valid", 32'(ov2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
